// File: rtl/addressed_demux_pkg.sv
// Shared definitions for the addressed demultiplexer: boolean constants and
// the per-channel slot state encoding.
package addressed_demux_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/addressed_demux_slot.sv
// One output channel: a single-word holding register with an EMPTY/FULL
// state machine. o_valid is the registered state, so it doubles as the debug view.
module addressed_demux_slot
  import addressed_demux_pkg::*;
#(
  parameter int WORD_WIDTH = 36
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic [WORD_WIDTH-1:0] i_data,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [WORD_WIDTH-1:0] o_data
);

  slot_state_t           r_state;
  logic [WORD_WIDTH-1:0] r_data;

  // i_load is only raised by the top when the slot is EMPTY or draining this
  // edge, so a load always wins and a same-edge drain+fill leaves no bubble.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= SLOT_EMPTY;
      r_data  <= '0;
    end else begin
      case (r_state)
        SLOT_EMPTY: begin
          if (i_load) begin
            r_data  <= i_data;
            r_state <= SLOT_FULL;
          end
        end
        SLOT_FULL: begin
          if (i_load) begin
            r_data  <= i_data;
            r_state <= SLOT_FULL;
          end else if (i_ready) begin
            r_state <= SLOT_EMPTY;
          end
        end
        default: r_state <= SLOT_EMPTY;
      endcase
    end
  end

  assign o_valid = (r_state == SLOT_FULL) ? TRUE : FALSE;
  assign o_data  = r_data;

endmodule

// File: rtl/addressed_demux.sv
// Routes each input word to the slot selected by in_addr. Handshake: a word
// moves on any edge where its valid and ready are both 1; ready never waits on valid.
module addressed_demux
  import addressed_demux_pkg::*;
#(
  parameter int WORD_WIDTH   = 36,
  parameter int ADDR_WIDTH   = 2,
  parameter int OUTPUT_COUNT = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [ADDR_WIDTH-1:0]              in_addr,
  input  logic [WORD_WIDTH-1:0]              in_data,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [WORD_WIDTH*OUTPUT_COUNT-1:0] out_data,
  output logic [OUTPUT_COUNT-1:0]            out_valid,
  input  logic [OUTPUT_COUNT-1:0]            out_ready,
  output logic                               addr_error
);

  localparam logic [ADDR_WIDTH:0] LP_COUNT = OUTPUT_COUNT[ADDR_WIDTH:0];

  if (OUTPUT_COUNT > (1 << ADDR_WIDTH)) begin : g_bad_cfg
    $error("addressed_demux: OUTPUT_COUNT exceeds the address range");
  end

  logic                    w_in_range;
  logic                    w_sel_free;
  logic                    w_accept;
  logic [OUTPUT_COUNT-1:0] w_load;
  logic                    r_addr_error;

  assign w_in_range = ({1'b0, in_addr} < LP_COUNT) ? TRUE : FALSE;

  always_comb begin
    w_sel_free = FALSE;
    for (int k = 0; k < OUTPUT_COUNT; k++) begin
      if (in_addr == ADDR_WIDTH'(k)) begin
        w_sel_free = ~out_valid[k] | out_ready[k];
      end
    end
  end

  // Out-of-range words are always accepted so they can be dropped and flagged.
  assign in_ready = ~reset & (~w_in_range | w_sel_free);
  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_load = '0;
    for (int k = 0; k < OUTPUT_COUNT; k++) begin
      w_load[k] = w_accept & w_in_range & (in_addr == ADDR_WIDTH'(k));
    end
  end

  for (genvar g = 0; g < OUTPUT_COUNT; g++) begin : g_slot
    addressed_demux_slot #(
      .WORD_WIDTH(WORD_WIDTH)
    ) u_slot (
      .clock  (clock),
      .reset  (reset),
      .i_load (w_load[g]),
      .i_data (in_data),
      .i_ready(out_ready[g]),
      .o_valid(out_valid[g]),
      .o_data (out_data[g*WORD_WIDTH +: WORD_WIDTH])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr_error <= FALSE;
    end else begin
      r_addr_error <= w_accept & ~w_in_range;
    end
  end

  assign addr_error = r_addr_error;

endmodule

// File: tb/tb_addressed_demux.sv
// Directed checks of addressed_demux (4- and 3-channel builds) followed by a
// randomized run against per-channel expected queues.
module tb_addressed_demux;

  localparam int W  = 36;
  localparam int AW = 2;
  localparam int N  = 4;
  localparam int N3 = 3;

  logic            clock;
  logic            reset;
  logic [AW-1:0]   in_addr;
  logic [W-1:0]    in_data;
  logic            in_valid;
  logic            in_ready;
  logic [W*N-1:0]  out_data;
  logic [N-1:0]    out_valid;
  logic [N-1:0]    out_ready;
  logic            addr_error;

  logic [AW-1:0]   b_in_addr;
  logic [W-1:0]    b_in_data;
  logic            b_in_valid;
  logic            b_in_ready;
  logic [W*N3-1:0] b_out_data;
  logic [N3-1:0]   b_out_valid;
  logic [N3-1:0]   b_out_ready;
  logic            b_addr_error;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[N][$];

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  addressed_demux #(.WORD_WIDTH(W), .ADDR_WIDTH(AW), .OUTPUT_COUNT(N)) dut (
    .clock(clock), .reset(reset), .in_addr(in_addr), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .addr_error(addr_error)
  );

  addressed_demux #(.WORD_WIDTH(W), .ADDR_WIDTH(AW), .OUTPUT_COUNT(N3)) dut3 (
    .clock(clock), .reset(reset), .in_addr(b_in_addr), .in_data(b_in_data),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .addr_error(b_addr_error)
  );

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [AW-1:0] a, input logic [W-1:0] d, input logic v);
    in_addr  = a;
    in_data  = d;
    in_valid = v;
  endtask

  task automatic check(input string tag, input logic [W*N-1:0] obs, input logic [W*N-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [N-1:0]  rv_ready;
    logic [AW-1:0] ra;
    logic [W-1:0]  rd;
    logic          rv;
    logic          exp_rdy;

    reset = 1'b1;
    drive('0, '0, 1'b0);
    out_ready   = '0;
    b_in_addr   = '0;
    b_in_data   = '0;
    b_in_valid  = 1'b0;
    b_out_ready = '0;
    #1;
    check("rst_in_ready", in_ready, 0);
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_addr_error", addr_error, 0);
    check("rst_in_ready2", in_ready, 0);
    reset = 1'b0;
    #1;

    // single word to channel 2, one-cycle latency
    drive(2, 36'h123456789, 1'b1);
    #1;
    check("ch2_in_ready", in_ready, 1);
    tick();
    drive(0, '0, 1'b0);
    check("ch2_out_valid", out_valid, 4'b0100);
    check("ch2_out_data", out_data, {36'h0, 36'h123456789, 72'h0});

    // fill channel 1, then stall it
    drive(1, 36'h0000AAAAA, 1'b1);
    tick();
    drive(1, 36'h0000BBBBB, 1'b1);
    #1;
    check("ch1_stall_ready", in_ready, 0);
    tick();
    check("ch1_stall_data", out_data[1*W +: W], 36'h0000AAAAA);
    check("ch1_stall_valid", out_valid, 4'b0110);
    check("ch1_stall_ready2", in_ready, 0);

    // other channel is not blocked by the stalled one
    drive(3, 36'h0000CCCCC, 1'b1);
    #1;
    check("ch3_ready", in_ready, 1);
    tick();
    check("ch3_valid", out_valid, 4'b1110);
    check("ch3_data", out_data[3*W +: W], 36'h0000CCCCC);
    check("ch1_hold", out_data[1*W +: W], 36'h0000AAAAA);

    // drain and refill channel 1 on the same edge
    drive(1, 36'h0000BBBBB, 1'b1);
    out_ready = 4'b0010;
    #1;
    check("ch1_refill_ready", in_ready, 1);
    tick();
    drive(0, '0, 1'b0);
    out_ready = '0;
    check("ch1_refill_data", out_data[1*W +: W], 36'h0000BBBBB);
    check("ch1_refill_valid", out_valid, 4'b1110);

    // drain channel 3; data stays while empty
    out_ready = 4'b1000;
    tick();
    out_ready = '0;
    check("ch3_drain_valid", out_valid, 4'b0110);
    check("ch3_empty_data", out_data[3*W +: W], 36'h0000CCCCC);
    tick();
    check("ch3_drain_valid2", out_valid, 4'b0110);

    // mid-operation reset with consumers ready
    drive(0, 36'h00000DDDD, 1'b1);
    tick();
    drive(0, '0, 1'b0);
    check("ch0_fill", out_valid, 4'b0111);
    reset = 1'b1;
    out_ready = '1;
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    tick();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_in_ready2", in_ready, 0);
    reset = 1'b0;
    out_ready = '0;
    drive(0, 36'h00000EEEE, 1'b1);
    tick();
    drive(0, '0, 1'b0);
    check("post_rst_valid", out_valid, 4'b0001);
    check("post_rst_data", out_data, {108'h0, 36'h00000EEEE});

    // 3-channel build: out-of-range address is dropped and flagged once
    b_in_addr  = 0;
    b_in_data  = 36'h000000111;
    b_in_valid = 1'b1;
    tick();
    b_in_addr = 3;
    b_in_data = 36'h000000999;
    #1;
    check("oor_ready", b_in_ready, 1);
    check("oor_no_err_yet", b_addr_error, 0);
    tick();
    b_in_valid = 1'b0;
    check("oor_err", b_addr_error, 1);
    check("oor_valid", b_out_valid, 3'b001);
    check("oor_data", b_out_data, {72'h0, 36'h000000111});
    tick();
    check("oor_err_clear", b_addr_error, 0);
    check("main_no_err", addr_error, 0);

    // randomized traffic against the expected queues
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      ra       = AW'($urandom_range(0, N - 1));
      rd       = {4'($urandom_range(0, 15)), 32'($urandom)};
      rv       = 1'($urandom_range(0, 1));
      rv_ready = N'($urandom_range(0, (1 << N) - 1));
      drive(ra, rd, rv);
      out_ready = rv_ready;
      #1;
      exp_rdy = (exp_q[ra].size() == 0) | rv_ready[ra];
      check("rnd_in_ready", in_ready, exp_rdy);
      for (int k = 0; k < N; k++) begin
        check("rnd_out_valid", out_valid[k], exp_q[k].size() != 0);
        if (exp_q[k].size() != 0 && rv_ready[k]) begin
          check("rnd_out_data", out_data[k*W +: W], exp_q[k].pop_front());
        end
      end
      if (rv && exp_rdy) exp_q[ra].push_back(rd);
      tick();
    end
    drive(0, '0, 1'b0);
    out_ready = '0;
    #1;
    for (int k = 0; k < N; k++) begin
      check("end_occupancy", out_valid[k], exp_q[k].size() != 0);
      if (exp_q[k].size() != 0) check("end_data", out_data[k*W +: W], exp_q[k][0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/addressed_demux.md
ADDRESSED_DEMUX -- requirements
Module: addressed_demux

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 36, width of each data word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 2, width of the destination address.
REQ-003 SHALL have parameter OUTPUT_COUNT, default 4, number of output channels; legal only when OUTPUT_COUNT <= 2**ADDR_WIDTH.
REQ-004 SHALL have port clock, input, 1, sole clock; all state updates on posedge clock.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port in_addr, input, ADDR_WIDTH, destination channel of the current input word.
REQ-007 SHALL have port in_data, input, WORD_WIDTH, input word.
REQ-008 SHALL have port in_valid, input, 1, input word and address valid.
REQ-009 SHALL have port in_ready, output, 1, the block accepts the input word this cycle.
REQ-010 SHALL have port out_data, output, WORD_WIDTH*OUTPUT_COUNT, concatenated channel words; channel k occupies bits [k*WORD_WIDTH +: WORD_WIDTH].
REQ-011 SHALL have port out_valid, output, OUTPUT_COUNT, per-channel word valid.
REQ-012 SHALL have port out_ready, input, OUTPUT_COUNT, per-channel consumer ready.
REQ-013 SHALL have port addr_error, output, 1, one-cycle pulse flagging a dropped out-of-range transfer.

Function
REQ-014 Each channel SHALL hold exactly one word in a slot register, states EMPTY (out_valid[k]=0) and FULL (out_valid[k]=1).
REQ-015 An input transfer SHALL occur when in_valid and in_ready are both 1 on a clock edge.
REQ-016 in_ready SHALL be combinational: 0 during reset; 1 if in_addr >= OUTPUT_COUNT; otherwise (~out_valid[in_addr]) | out_ready[in_addr].
REQ-017 A transfer to in-range channel a SHALL load in_data into slot a and set out_valid[a]=1 at the next edge; latency is exactly 1 cycle.
REQ-018 A channel output transfer SHALL occur when out_valid[k] and out_ready[k] are both 1; slot k then goes EMPTY unless refilled on the same edge.
REQ-019 Simultaneous drain and fill of the same channel SHALL leave out_valid[k]=1 with the new word and no bubble.
REQ-020 While out_valid[k]=1 and out_ready[k]=0, out_data for channel k SHALL stay constant.
REQ-021 An EMPTY channel's out_data SHALL keep its last loaded value (0 after reset).
REQ-022 Channels SHALL operate independently; a stalled channel SHALL block only inputs addressed to it.
REQ-023 A transfer with in_addr >= OUTPUT_COUNT SHALL be accepted, discarded, and make addr_error 1 for exactly the next cycle; no slot changes.
REQ-024 addr_error SHALL be 0 in every cycle not following an out-of-range transfer.
REQ-025 Words to one channel SHALL be delivered in acceptance order, without loss or duplication.

Reset
REQ-026 While reset=1 at an edge: all out_valid SHALL be 0, all out_data 0, and addr_error 0 after that edge.
REQ-027 Reset mid-operation SHALL discard all held words; no output transfer is reported during reset cycles even if out_ready=1.
REQ-028 in_ready SHALL be 0 in every cycle reset is asserted.

Structure
REQ-029 Boolean values SHALL come from the codebase's shared TRUE/FALSE definitions; no other shared package or typedef is required.
REQ-030 The per-channel slot (data register, valid flag, load/drain logic) SHALL be a sub-module addressed_demux_slot, instantiated OUTPUT_COUNT times in a generate loop.
REQ-031 The top level SHALL contain only address decode, in_ready selection, and addr_error register.

Verification
REQ-032 Reset, then in_addr=2, in_data=0x123456789, in_valid=1 for one cycle, out_ready=0 -> next cycle out_valid=4'b0100, channel 2 out_data=0x123456789, others 0.
REQ-033 Channel 1 FULL, out_ready[1]=0, in_addr=1 in_valid=1 -> in_ready=0 until out_ready[1]=1; on that edge new word loads, out_valid[1] stays 1.
REQ-034 Channel 1 FULL stalled, in_addr=3 in_valid=1 -> in_ready=1, channel 3 fills next cycle; channel 1 data unchanged.
REQ-035 OUTPUT_COUNT=3, ADDR_WIDTH=2, in_addr=3 in_valid=1 -> in_ready=1, addr_error=1 for exactly one cycle, out_valid unchanged.
REQ-036 Channels 0 and 2 FULL, assert reset one cycle -> out_valid=0, out_data=0, in_ready=0 during reset; a write after reset completes normally.
REQ-037 Random in_valid/in_addr/out_ready for 10000 cycles against a per-channel FIFO scoreboard -> every word delivered once, in order, to its addressed channel.
